// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button sync/edge detect, run/pause/lap/clear FSM,
// prescaled two-digit BCD up/down counter with lap capture and wrap pulse.
// Ports: clkin, rst (sync, active-high), btn_start/btn_lap/btn_clr/dir (async),
//   disp_one/disp_ten (BCD), state (IDLE=0 RUN=1 PAUSE=2 LAP=3), wrap (pulse).
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic       dir,
  output logic [3:0] disp_one,
  output logic [3:0] disp_ten,
  output logic [1:0] state,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  state_t cur, nxt;

  // bit 0 = start, bit 1 = lap, bit 2 = clr
  logic [2:0] sync1, sync2, hist, pulse;
  logic dir1, dir2;

  logic [PW-1:0] pre;
  logic [3:0] one, ten, cap_one, cap_ten;
  logic [3:0] nxt_one, nxt_ten;
  logic run, tick, cap_en, clr_en, wrap_nxt;

  // Sync and history regs reset high so a button held through reset
  // must be released and pressed again before it produces a pulse.
  always_ff @(posedge clkin) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      hist  <= '1;
      dir1  <= 1'b0;
      dir2  <= 1'b0;
    end else begin
      sync1 <= {btn_clr, btn_lap, btn_start};
      sync2 <= sync1;
      hist  <= sync2;
      dir1  <= dir;
      dir2  <= dir1;
    end
  end

  assign pulse = sync2 & ~hist;

  always_ff @(posedge clkin) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  // Only legal pulses are considered; among them clr > start > lap.
  always_comb begin
    nxt    = cur;
    cap_en = 1'b0;
    clr_en = 1'b0;
    unique case (cur)
      IDLE: begin
        if (pulse[0]) nxt = RUN;
      end
      RUN: begin
        if (pulse[0]) begin
          nxt = PAUSE;
        end else if (pulse[1]) begin
          nxt    = LAP;
          cap_en = 1'b1;
        end
      end
      PAUSE: begin
        if (pulse[2]) begin
          nxt    = IDLE;
          clr_en = 1'b1;
        end else if (pulse[0]) begin
          nxt = RUN;
        end
      end
      LAP: begin
        if (pulse[0])      nxt = PAUSE;
        else if (pulse[1]) nxt = RUN;
      end
    endcase
  end

  assign run  = (cur == RUN) || (cur == LAP);
  assign tick = run && (pre == PMAX);

  always_comb begin
    nxt_one  = one;
    nxt_ten  = ten;
    wrap_nxt = 1'b0;
    if (!dir2) begin
      if (one == 4'd9) begin
        nxt_one = 4'd0;
        if (ten == 4'd9) begin
          nxt_ten  = 4'd0;
          wrap_nxt = 1'b1;
        end else begin
          nxt_ten = ten + 4'd1;
        end
      end else begin
        nxt_one = one + 4'd1;
      end
    end else begin
      if (one == 4'd0) begin
        nxt_one = 4'd9;
        if (ten == 4'd0) begin
          nxt_ten  = 4'd9;
          wrap_nxt = 1'b1;
        end else begin
          nxt_ten = ten - 4'd1;
        end
      end else begin
        nxt_one = one - 4'd1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      pre      <= '0;
      one      <= 4'd0;
      ten      <= 4'd0;
      cap_one  <= 4'd0;
      cap_ten  <= 4'd0;
      wrap     <= 1'b0;
      disp_one <= 4'd0;
      disp_ten <= 4'd0;
    end else begin
      wrap <= tick & wrap_nxt;
      if (clr_en || cur == IDLE) pre <= '0;
      else if (run)              pre <= tick ? '0 : pre + PW'(1);
      if (clr_en) begin
        one <= 4'd0;
        ten <= 4'd0;
      end else if (tick) begin
        one <= nxt_one;
        ten <= nxt_ten;
      end
      if (cap_en) begin
        cap_one <= one;
        cap_ten <= ten;
      end
      if (cur == LAP) begin
        disp_one <= cap_one;
        disp_ten <= cap_ten;
      end else begin
        disp_one <= one;
        disp_ten <= ten;
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (TICK_DIV=4): directed button sequences, an
// integer-count reference model compared every cycle, plus literal pins.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic clkin = 1'b0;
  logic rst = 1'b1;
  logic btn_start = 1'b0;
  logic btn_lap = 1'b0;
  logic btn_clr = 1'b0;
  logic dir = 1'b0;
  logic [3:0] disp_one, disp_ten;
  logic [1:0] state;
  logic wrap;

  int errors = 0;
  int checks = 0;

  always #5 clkin = ~clkin;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clkin(clkin),
    .rst(rst),
    .btn_start(btn_start),
    .btn_lap(btn_lap),
    .btn_clr(btn_clr),
    .dir(dir),
    .disp_one(disp_one),
    .disp_ten(disp_ten),
    .state(state),
    .wrap(wrap)
  );

  // Input values as seen by the DUT on each rising edge.
  logic s_rst;
  logic [2:0] s_btn;
  logic s_dir;
  always @(posedge clkin) begin
    s_rst <= rst;
    s_btn <= {btn_clr, btn_lap, btn_start};
    s_dir <= dir;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  // Reference model: count kept as an integer 0..99.
  int m_st, m_pre, m_cnt, m_cap, m_disp;
  bit m_wrap;
  bit [2:0] m_s1, m_s2, m_h;
  bit m_d1, m_d2;

  task automatic model_step();
    bit [2:0] pul;
    bit tk;
    int ncnt, npre, nst;
    if (s_rst) begin
      m_st = 0; m_pre = 0; m_cnt = 0; m_cap = 0; m_disp = 0;
      m_wrap = 0;
      m_s1 = '1; m_s2 = '1; m_h = '1;
      m_d1 = 0; m_d2 = 0;
    end else begin
      pul = m_s2 & ~m_h;
      m_disp = (m_st == 3) ? m_cap : m_cnt;
      tk = (m_st == 1 || m_st == 3) && (m_pre == TD - 1);
      ncnt = m_cnt;
      m_wrap = 0;
      if (tk) begin
        if (m_d2) begin
          ncnt = (m_cnt + 99) % 100;
          m_wrap = (m_cnt == 0);
        end else begin
          ncnt = (m_cnt + 1) % 100;
          m_wrap = (m_cnt == 99);
        end
      end
      if (m_st == 1 || m_st == 3) npre = tk ? 0 : m_pre + 1;
      else if (m_st == 0)         npre = 0;
      else                        npre = m_pre;
      nst = m_st;
      case (m_st)
        0: if (pul[0]) nst = 1;
        1: begin
          if (pul[0]) nst = 2;
          else if (pul[1]) begin
            nst = 3;
            m_cap = m_cnt;
          end
        end
        2: begin
          if (pul[2]) begin
            nst = 0; ncnt = 0; npre = 0;
          end else if (pul[0]) nst = 1;
        end
        default: begin
          if (pul[0]) nst = 2;
          else if (pul[1]) nst = 1;
        end
      endcase
      m_st = nst; m_cnt = ncnt; m_pre = npre;
      m_h = m_s2; m_s2 = m_s1; m_s1 = s_btn;
      m_d2 = m_d1; m_d1 = s_dir;
    end
  endtask

  initial begin
    forever begin
      @(negedge clkin);
      model_step();
      chk("model_disp", int'({disp_ten, disp_one}), bcd(m_disp));
      chk("model_state", int'(state), m_st);
      chk("model_wrap", int'(wrap), int'(m_wrap));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clkin);
  endtask

  // m: bit0 start, bit1 lap, bit2 clr. Acts on the 3rd edge after the call.
  task automatic press(input logic [2:0] m);
    {btn_clr, btn_lap, btn_start} = m;
    @(negedge clkin);
    {btn_clr, btn_lap, btn_start} = 3'b000;
  endtask

  // Reset, then start; returns just after the edge that enters RUN (E3).
  task automatic start_run();
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    wait_n(4);
    press(3'b001);
    wait_n(1);
    chk("pre_start_state", int'(state), 0);
    wait_n(1);
    chk("start_state", int'(state), 1);
  endtask

  initial begin
    wait_n(3);
    rst = 1'b0;
    wait_n(4);
    chk("reset_state", int'(state), 0);
    chk("reset_disp", int'({disp_ten, disp_one}), 0);
    chk("reset_wrap", int'(wrap), 0);

    // count up, full wrap
    start_run();
    wait_n(4);
    chk("t1_before_tick", int'({disp_ten, disp_one}), bcd(0));
    wait_n(1);
    chk("t1_first_tick", int'({disp_ten, disp_one}), bcd(1));
    wait_n(394);
    chk("t1_disp99", int'({disp_ten, disp_one}), bcd(99));
    chk("t1_nowrap", int'(wrap), 0);
    wait_n(1);
    chk("t1_wrap_hi", int'(wrap), 1);
    wait_n(1);
    chk("t1_wrap_lo", int'(wrap), 0);
    chk("t1_disp00", int'({disp_ten, disp_one}), bcd(0));

    // count down from 00
    dir = 1'b1;
    start_run();
    wait_n(4);
    chk("t2_wrap", int'(wrap), 1);
    wait_n(1);
    chk("t2_disp99", int'({disp_ten, disp_one}), bcd(99));
    chk("t2_wrap_lo", int'(wrap), 0);
    wait_n(4);
    chk("t2_disp98", int'({disp_ten, disp_one}), bcd(98));
    dir = 1'b0;

    // lap freeze at 12, release at 17
    start_run();
    wait_n(47);
    press(3'b010);
    wait_n(2);
    chk("t3_lap_state", int'(state), 3);
    wait_n(1);
    chk("t3_lap_disp", int'({disp_ten, disp_one}), bcd(12));
    wait_n(6);
    chk("t3_lap_hold", int'({disp_ten, disp_one}), bcd(12));
    wait_n(10);
    press(3'b010);
    wait_n(2);
    chk("t3_rel_state", int'(state), 1);
    wait_n(1);
    chk("t3_rel_disp", int'({disp_ten, disp_one}), bcd(17));

    // pause at 05 with prescaler 2, resume
    start_run();
    wait_n(19);
    press(3'b001);
    wait_n(2);
    chk("t4_pause_state", int'(state), 2);
    wait_n(1);
    chk("t4_pause_disp", int'({disp_ten, disp_one}), bcd(5));
    wait_n(100);
    chk("t4_pause_hold", int'({disp_ten, disp_one}), bcd(5));
    chk("t4_pause_state2", int'(state), 2);
    press(3'b001);
    wait_n(2);
    chk("t4_resume_state", int'(state), 1);
    wait_n(2);
    chk("t4_resume_early", int'({disp_ten, disp_one}), bcd(5));
    wait_n(1);
    chk("t4_resume_tick", int'({disp_ten, disp_one}), bcd(6));

    // clear with start in PAUSE, illegal clr, held button across reset
    start_run();
    wait_n(146);
    press(3'b001);
    wait_n(2);
    chk("t5_pause_state", int'(state), 2);
    wait_n(1);
    chk("t5_pause_disp", int'({disp_ten, disp_one}), bcd(37));
    press(3'b101);
    wait_n(2);
    chk("t5_clr_state", int'(state), 0);
    wait_n(1);
    chk("t5_clr_disp", int'({disp_ten, disp_one}), bcd(0));
    press(3'b001);
    wait_n(2);
    chk("t5_run_state", int'(state), 1);
    press(3'b100);
    wait_n(2);
    chk("t5_clr_in_run", int'(state), 1);
    press(3'b010);
    wait_n(2);
    chk("t5_lap_state", int'(state), 3);
    press(3'b100);
    wait_n(2);
    chk("t5_clr_in_lap", int'(state), 3);
    rst = 1'b1;
    btn_start = 1'b1;
    wait_n(3);
    rst = 1'b0;
    wait_n(6);
    chk("t5_held_no_pulse", int'(state), 0);
    btn_start = 1'b0;
    wait_n(4);
    chk("t5_release_idle", int'(state), 0);
    press(3'b001);
    wait_n(2);
    chk("t5_repress_run", int'(state), 1);

    // reset mid-run at 42
    start_run();
    wait_n(169);
    chk("t6_disp42", int'({disp_ten, disp_one}), bcd(42));
    rst = 1'b1;
    wait_n(1);
    chk("t6_rst_state", int'(state), 0);
    chk("t6_rst_disp", int'({disp_ten, disp_one}), 0);
    chk("t6_rst_wrap", int'(wrap), 0);
    rst = 1'b0;
    wait_n(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
